repetition_serializer: RTL and testbench

- Consumer for the repetition-detector output stream.
- Each input beat carries one group of GROUP_SIZE activations plus a GROUP_SIZE x GROUP_SIZE repetition-info matrix.
- The block emits only the unique values, one per output beat. Each beat carries the element index and a mask of all positions that share that value, so a single downstream arithmetic lane can process unique values and scatter results.
- Iteration-controlled like the other stream blocks: configured once, then self-disables after num_iters*num_reads_per_iter groups.

---
 rtl/repetition_serializer_if.sv | 28 ++
 rtl/repetition_serializer.sv | 172 +++++++++++++++++
 tb/tb_repetition_serializer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/repetition_serializer_if.sv
// Stream bundle for the repetition serializer: grouped activations in, one unique value per beat out.
interface repetition_serializer_if #(
  parameter int GROUP_SIZE     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int LOG_GROUP_SIZE = 2
);
  localparam int REP_INFO = GROUP_SIZE * GROUP_SIZE;

  logic [GROUP_SIZE*DATA_WIDTH+REP_INFO-1:0] data_in;
  logic                                      valid_in;
  logic                                      avail_out;
  logic [DATA_WIDTH-1:0]                     value_out;
  logic [LOG_GROUP_SIZE-1:0]                 idx_out;
  logic [GROUP_SIZE-1:0]                     mask_out;
  logic                                      last_out;
  logic                                      valid_out;
  logic                                      avail_in;

  modport slave (
    input  data_in, valid_in, avail_in,
    output avail_out, value_out, idx_out, mask_out, last_out, valid_out
  );

  modport master (
    output data_in, valid_in, avail_in,
    input  avail_out, value_out, idx_out, mask_out, last_out, valid_out
  );
endinterface

// File: rtl/repetition_serializer.sv
// Turns one group plus its repetition matrix into a sequence of unique-value beats,
// each carrying the first-occurrence index and the scatter mask of equal positions.
module repetition_serializer #(
  parameter int GROUP_SIZE             = 4,
  parameter int DATA_WIDTH             = 8,
  parameter int LOG_GROUP_SIZE         = 2,
  parameter int LOG_MAX_ITERS          = 16,
  parameter int LOG_MAX_READS_PER_ITER = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              configure,
  input  logic [LOG_MAX_ITERS-1:0]          num_iters,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_per_iter,
  repetition_serializer_if.slave            stream,
  output logic                              err_out
);
  localparam int REP_INFO  = GROUP_SIZE * GROUP_SIZE;
  localparam int ELEM_BITS = GROUP_SIZE * DATA_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic logic [LOG_GROUP_SIZE-1:0] lowest_set(input logic [GROUP_SIZE-1:0] bits);
    logic [LOG_GROUP_SIZE-1:0] idx;
    idx = '0;
    for (int i = GROUP_SIZE - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx = LOG_GROUP_SIZE'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [GROUP_SIZE-1:0] bits);
    return (bits != '0) && ((bits & (bits - GROUP_SIZE'(1))) == '0);
  endfunction

  state_t                                     state_r;
  logic                                       enabled_r;
  logic [LOG_MAX_ITERS-1:0]                   iters_r;
  logic [LOG_MAX_READS_PER_ITER-1:0]          reads_r;
  logic [LOG_MAX_READS_PER_ITER-1:0]          copy_r;
  logic [GROUP_SIZE-1:0][DATA_WIDTH-1:0]      elem_r;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]      rows_r;
  logic [GROUP_SIZE-1:0]                      pending_r;
  logic                                       err_r;

  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]      raw_s;
  logic [GROUP_SIZE-1:0][GROUP_SIZE-1:0]      rows_s;
  logic [GROUP_SIZE-1:0]                      pending_init_s;
  logic [GROUP_SIZE-1:0]                      seen_s;
  logic                                       overlap_s;
  logic                                       malformed_s;

  logic [LOG_GROUP_SIZE-1:0]                  sel_s;
  logic                                       emitting_s;
  logic                                       last_s;
  logic                                       handshake_s;
  logic                                       complete_s;
  logic                                       accept_s;

  assign raw_s = stream.data_in[ELEM_BITS +: REP_INFO];

  // Keep only the upper triangle and check the rows partition the group exactly once.
  always_comb begin
    rows_s         = '0;
    pending_init_s = '0;
    seen_s         = '0;
    overlap_s      = 1'b0;
    for (int r = 0; r < GROUP_SIZE; r++) begin
      for (int c = 0; c < GROUP_SIZE; c++) begin
        if (c >= r) begin
          rows_s[r][c] = raw_s[r][c];
        end else begin
          rows_s[r][c] = 1'b0;
        end
      end
      pending_init_s[r] = |rows_s[r];
      if ((seen_s & rows_s[r]) != '0) begin
        overlap_s = 1'b1;
      end else begin
        overlap_s = overlap_s;
      end
      seen_s = seen_s | rows_s[r];
    end
    malformed_s = (seen_s != '1) || overlap_s;
  end

  // Selection of the current unique value and the handshake/completion conditions.
  always_comb begin
    sel_s       = lowest_set(pending_r);
    emitting_s  = (state_r == EMIT) && (pending_r != '0);
    last_s      = single_bit(pending_r);
    handshake_s = emitting_s && stream.avail_in;
    complete_s  = ((state_r == EMIT) && (pending_r == '0)) || (handshake_s && last_s);
    accept_s    = stream.valid_in && enabled_r && (state_r == IDLE);
  end

  assign stream.avail_out = enabled_r && (state_r == IDLE);
  assign stream.valid_out = emitting_s;
  assign stream.value_out = emitting_s ? elem_r[sel_s] : '0;
  assign stream.idx_out   = emitting_s ? sel_s : '0;
  assign stream.mask_out  = emitting_s ? rows_r[sel_s] : '0;
  assign stream.last_out  = emitting_s && last_s;
  assign err_out          = err_r;

  // Group capture, emission bookkeeping and iteration countdown.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      enabled_r <= 1'b0;
      iters_r   <= '0;
      reads_r   <= '0;
      copy_r    <= '0;
      elem_r    <= '0;
      rows_r    <= '0;
      pending_r <= '0;
      err_r     <= 1'b0;
    end else if (configure) begin
      iters_r   <= num_iters;
      reads_r   <= num_reads_per_iter;
      copy_r    <= num_reads_per_iter;
      enabled_r <= 1'b1;
      pending_r <= '0;
      err_r     <= 1'b0;
      state_r   <= IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            elem_r    <= stream.data_in[ELEM_BITS-1:0];
            rows_r    <= rows_s;
            pending_r <= pending_init_s;
            if (malformed_s) begin
              err_r <= 1'b1;
            end
            state_r <= EMIT;
          end
        end
        EMIT: begin
          // An empty group produces no beats but still counts as consumed.
          if (pending_r == '0) begin
            err_r <= 1'b1;
          end
          if (handshake_s) begin
            pending_r[sel_s] <= 1'b0;
          end
          if (complete_s) begin
            state_r <= IDLE;
            if (reads_r == LOG_MAX_READS_PER_ITER'(1) && iters_r == LOG_MAX_ITERS'(1)) begin
              enabled_r <= 1'b0;
            end else if (reads_r == LOG_MAX_READS_PER_ITER'(1)) begin
              iters_r <= iters_r - LOG_MAX_ITERS'(1);
              reads_r <= copy_r;
            end else begin
              reads_r <= reads_r - LOG_MAX_READS_PER_ITER'(1);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          pending_r <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_repetition_serializer.sv
// Randomised and directed checks of the repetition serializer against a value-level model.
module tb_repetition_serializer;
  localparam int GS  = 4;
  localparam int DW  = 8;
  localparam int LGS = 2;
  localparam int EB  = GS * DW;

  typedef struct {
    logic [DW-1:0]  value;
    logic [LGS-1:0] idx;
    logic [GS-1:0]  mask;
    logic           last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        configure = 1'b0;
  logic [15:0] num_iters = 16'd0;
  logic [15:0] num_reads = 16'd0;
  logic        err_out;

  int    total = 0;
  int    bad = 0;
  int    remaining_groups = 0;
  beat_t exp_q[$];

  repetition_serializer_if #(.GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_GROUP_SIZE(LGS)) bus ();

  repetition_serializer #(
    .GROUP_SIZE(GS), .DATA_WIDTH(DW), .LOG_GROUP_SIZE(LGS),
    .LOG_MAX_ITERS(16), .LOG_MAX_READS_PER_ITER(16)
  ) dut (
    .clk(clk), .rst(rst), .configure(configure), .num_iters(num_iters),
    .num_reads_per_iter(num_reads), .stream(bus.slave), .err_out(err_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Unique values in first-occurrence order, mask = every position holding that value.
  task automatic model_values(input logic [EB-1:0] elems);
    logic [GS-1:0] done;
    beat_t b;
    done = '0;
    for (int r = 0; r < GS; r++) begin
      if (!done[r]) begin
        b.value = elems[r*DW +: DW];
        b.idx   = LGS'(r);
        b.mask  = '0;
        b.last  = 1'b0;
        for (int c = 0; c < GS; c++) begin
          if (elems[c*DW +: DW] == b.value) b.mask[c] = 1'b1;
        end
        done = done | b.mask;
        exp_q.push_back(b);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  // Beats derived directly from the matrix rows (used for malformed matrices).
  task automatic model_rows(input logic [EB-1:0] elems, input logic [GS*GS-1:0] mat);
    beat_t b;
    for (int r = 0; r < GS; r++) begin
      b.mask = '0;
      for (int c = r; c < GS; c++) b.mask[c] = mat[r*GS + c];
      if (b.mask != '0) begin
        b.value = elems[r*DW +: DW];
        b.idx   = LGS'(r);
        b.last  = 1'b0;
        exp_q.push_back(b);
      end
    end
    if (exp_q.size() > 0) exp_q[exp_q.size()-1].last = 1'b1;
  endtask

  // Detector-style matrix: first occurrences mark their matches, lower triangle is junk.
  function automatic logic [GS*GS-1:0] make_matrix(input logic [EB-1:0] elems);
    logic [GS*GS-1:0] m;
    bit first;
    m = '0;
    for (int r = 0; r < GS; r++) begin
      first = 1'b1;
      for (int c = 0; c < r; c++) begin
        if (elems[c*DW +: DW] == elems[r*DW +: DW]) first = 1'b0;
      end
      for (int c = 0; c < GS; c++) begin
        if (c < r) m[r*GS + c] = 1'($urandom_range(1));
        else if (first && elems[c*DW +: DW] == elems[r*DW +: DW]) m[r*GS + c] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [EB-1:0] rand_elems(input int maxv);
    logic [EB-1:0] e;
    for (int i = 0; i < GS; i++) e[i*DW +: DW] = DW'($urandom_range(maxv));
    return e;
  endfunction

  task automatic do_config(input int iters, input int reads);
    configure = 1'b1;
    num_iters = 16'(iters);
    num_reads = 16'(reads);
    @(posedge clk); #1;
    configure = 1'b0;
    remaining_groups = iters * reads;
  endtask

  task automatic feed(input logic [EB-1:0] elems, input logic [GS*GS-1:0] mat);
    int w = 0;
    while (!bus.avail_out && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("accept_ready", bus.avail_out, 1);
    bus.data_in  = {mat, elems};
    bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic drain(input int hold_first, input int stall_pct);
    int cyc = 0;
    while (exp_q.size() > 0 && cyc < 200) begin
      bus.avail_in = (cyc >= hold_first) && ($urandom_range(99) >= stall_pct);
      check("valid_out", bus.valid_out, 1);
      if (bus.valid_out) begin
        check("value_out", bus.value_out, exp_q[0].value);
        check("idx_out", bus.idx_out, exp_q[0].idx);
        check("mask_out", bus.mask_out, exp_q[0].mask);
        check("last_out", bus.last_out, exp_q[0].last);
        if (bus.avail_in) void'(exp_q.pop_front());
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.avail_in = 1'b0;
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    remaining_groups--;
    check("valid_after_group", bus.valid_out, 0);
    check("avail_after_group", bus.avail_out, remaining_groups > 0);
  endtask

  task automatic run_group(input logic [EB-1:0] elems, input logic [GS*GS-1:0] mat,
                           input int hold_first, input int stall_pct);
    model_values(elems);
    feed(elems, mat);
    drain(hold_first, stall_pct);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [EB-1:0] basic;
    logic [EB-1:0] e;
    basic = {8'd3, 8'd3, 8'd2, 8'd3};
    bus.data_in  = '0;
    bus.valid_in = 1'b0;
    bus.avail_in = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_avail", bus.avail_out, 0);
    check("rst_valid", bus.valid_out, 0);
    check("rst_value", bus.value_out, 0);
    check("rst_mask", bus.mask_out, 0);
    check("rst_last", bus.last_out, 0);
    check("rst_err", err_out, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("unconfigured_avail", bus.avail_out, 0);

    do_config(1, 100);
    check("cfg_avail", bus.avail_out, 1);

    run_group(basic, 16'b0000_0000_0010_1101, 0, 0);
    check("basic_err", err_out, 0);
    run_group({8'd4, 8'd3, 8'd2, 8'd1}, 16'b1000_0100_0010_0001, 0, 0);
    run_group({8'd7, 8'd7, 8'd7, 8'd7}, 16'h000F, 0, 0);
    run_group(basic, 16'b0000_0000_0010_1101, 3, 0);

    for (int g = 0; g < 40; g++) begin
      e = rand_elems((g < 20) ? 3 : 255);
      run_group(e, make_matrix(e), $urandom_range(2), 30);
    end
    check("random_err", err_out, 0);

    // Empty matrix: no beats, sticky error, group still consumed.
    feed(basic, '0);
    check("zero_no_beat", bus.valid_out, 0);
    check("zero_err", err_out, 1);
    @(posedge clk); #1;
    remaining_groups--;
    check("zero_back_idle", bus.avail_out, 1);
    check("zero_still_no_beat", bus.valid_out, 0);

    // Overlapping rows are flagged but still serialised row by row.
    model_rows({8'd8, 8'd7, 8'd6, 8'd5}, 16'b0000_1100_0010_0011);
    feed({8'd8, 8'd7, 8'd6, 8'd5}, 16'b0000_1100_0010_0011);
    drain(0, 0);
    run_group(basic, 16'b0000_0000_0010_1101, 0, 0);
    check("err_sticky", err_out, 1);

    // Configure in the middle of a group drops it and clears the error.
    feed(basic, 16'b0000_0000_0010_1101);
    check("mid_emit_valid", bus.valid_out, 1);
    do_config(2, 3);
    check("cfg_drop_valid", bus.valid_out, 0);
    check("cfg_clear_err", err_out, 0);
    check("cfg_idle_avail", bus.avail_out, 1);

    for (int g = 0; g < 6; g++) begin
      e = rand_elems(3);
      run_group(e, make_matrix(e), 0, 20);
    end
    bus.data_in  = {16'b0000_0000_0010_1101, basic};
    bus.valid_in = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      check("exhausted_no_beat", bus.valid_out, 0);
      check("exhausted_avail", bus.avail_out, 0);
    end
    bus.valid_in = 1'b0;
    do_config(1, 5);
    check("reenable_avail", bus.avail_out, 1);
    run_group(basic, 16'b0000_0000_0010_1101, 1, 0);

    // Reset while a group is being emitted.
    feed(basic, 16'b0000_0000_0010_1101);
    check("pre_rst_valid", bus.valid_out, 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", bus.valid_out, 0);
    check("midrst_avail", bus.avail_out, 0);
    check("midrst_mask", bus.mask_out, 0);
    check("midrst_err", err_out, 0);
    rst = 1'b1;
    exp_q.delete();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
